// File: rtl/vicii_timing_pkg.sv
// Shared timing types and constants for the phi-cycle generator.
package vicii_timing_pkg;

  localparam int PHI_TICKS  = 32;  // dot4x ticks per phi cycle (8 pixels x 4)
  localparam int HALF_TICKS = 16;  // dot4x ticks per phi half-cycle

  typedef logic [4:0] phase_t;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2
  } phi_state_t;

  localparam phase_t PHASE_LAST = phase_t'(PHI_TICKS - 1);   // phi0 falls after this
  localparam phase_t PHASE_RISE = phase_t'(HALF_TICKS - 1);  // phi0 rises after this

endpackage

// File: rtl/dram_strobe_gen.sv
// DRAM RAS/CAS strobe generation from the position within a phi half-cycle.
// Inputs are the next-tick values so the strobes line up with the phase register.
module dram_strobe_gen
  import vicii_timing_pkg::*;
#(
  parameter int RAS_FALL   = 5,
  parameter int CAS_FALL   = 9,
  parameter int STROBE_END = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       active_d,
  input  logic [3:0] half_pos_d,
  output logic       ras_n,
  output logic       cas_n
);

  localparam logic [3:0] RAS_POS = 4'(RAS_FALL);
  localparam logic [3:0] CAS_POS = 4'(CAS_FALL);
  localparam logic [3:0] END_POS = 4'(STROBE_END);

  logic ras_n_d, ras_n_q;
  logic cas_n_d, cas_n_q;

  // Decode the active-low strobe windows within the half-cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ras_n_d = 1'b1;
    cas_n_d = 1'b1;
    if (active_d) begin
      ras_n_d = !((half_pos_d >= RAS_POS) && (half_pos_d < END_POS));
      cas_n_d = !((half_pos_d >= CAS_POS) && (half_pos_d < END_POS));
    end
  end

  // Register the strobes; reset leaves the DRAM idle (both high).
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every flop sees pre-edge values.
    if (!rst_n) begin
      ras_n_q <= 1'b1;
      cas_n_q <= 1'b1;
    end else begin
      ras_n_q <= ras_n_d;
      cas_n_q <= cas_n_d;
    end
  end

  assign ras_n = ras_n_q;
  assign cas_n = cas_n_q;

endmodule

// File: rtl/phi_phase_gen.sv
// Phi-cycle generator: divides the 4x dot clock into the 32-tick phi cycle and
// produces dot enable, phi0, its edge strobes and DRAM RAS/CAS. Waits for the
// clock to settle after reset, and drains to the end of the current phi cycle
// before re-settling when the chip model changes. rst_n is expected to be
// released synchronously to clk_dot4x by the upstream reset controller.
module phi_phase_gen
  import vicii_timing_pkg::*;
#(
  parameter int SETTLE_TICKS = 1024,
  parameter int RAS_FALL     = 5,
  parameter int CAS_FALL     = 9,
  parameter int STROBE_END   = 14
) (
  input  logic       clk_dot4x,
  input  logic       rst_n,
  input  logic [1:0] chip,
  output logic       run,
  output logic [4:0] phase,
  output logic       dot_tick,
  output logic       clk_phi,
  output logic       phi_rise,
  output logic       phi_fall,
  output logic       ras_n,
  output logic       cas_n
);

  localparam int                CNT_W    = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_TICKS - 1);

  phi_state_t       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  phase_t           phase_d, phase_q;
  logic [1:0]       chip_q;
  logic             chip_vld_q;
  logic             chip_change;
  logic             run_d, run_q;
  logic             dot_tick_d, dot_tick_q;
  logic             clk_phi_d, clk_phi_q;
  logic             phi_rise_d, phi_rise_q;
  logic             phi_fall_d, phi_fall_q;

  // Sequencer: settle wait, free-running phase, and drain to the cycle end.
  always_comb begin
    chip_change = chip_vld_q && (chip != chip_q);
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    unique case (state_q)
      SETTLE: begin
        phase_d = '0;
        if (chip_change) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        phase_d = phase_q + 5'd1;
        if (chip_change) state_d = DRAIN;
      end
      DRAIN: begin
        // Further chip changes are ignored here; the exit point is fixed by phase.
        if (phase_q == PHASE_LAST) begin
          state_d = SETTLE;
          cnt_d   = '0;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 5'd1;
        end
      end
      default: begin
        state_d = SETTLE;
        cnt_d   = '0;
        phase_d = '0;
      end
    endcase
  end

  // Output decode from next-tick state so outputs register alongside phase.
  always_comb begin
    run_d      = (state_d != SETTLE);
    dot_tick_d = run_d && (phase_d[1:0] == 2'b11);
    clk_phi_d  = run_d && phase_d[4];
    phi_rise_d = run_d && (phase_d == PHASE_RISE);
    phi_fall_d = run_d && (phase_d == PHASE_LAST);
  end

  // Sequencer and output registers.
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SETTLE;
      cnt_q      <= '0;
      phase_q    <= '0;
      // NOTE: chip_q is reset too, but chip_vld_q masks the first post-reset
      // sample so an arbitrary reset value cannot fake a chip change.
      chip_q     <= '0;
      chip_vld_q <= 1'b0;
      run_q      <= 1'b0;
      dot_tick_q <= 1'b0;
      clk_phi_q  <= 1'b0;
      phi_rise_q <= 1'b0;
      phi_fall_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      chip_q     <= chip;
      chip_vld_q <= 1'b1;
      run_q      <= run_d;
      dot_tick_q <= dot_tick_d;
      clk_phi_q  <= clk_phi_d;
      phi_rise_q <= phi_rise_d;
      phi_fall_q <= phi_fall_d;
    end
  end

  dram_strobe_gen #(
    .RAS_FALL   (RAS_FALL),
    .CAS_FALL   (CAS_FALL),
    .STROBE_END (STROBE_END)
  ) u_dram_strobe_gen (
    .clk        (clk_dot4x),
    .rst_n      (rst_n),
    .active_d   (run_d),
    .half_pos_d (phase_d[3:0]),
    .ras_n      (ras_n),
    .cas_n      (cas_n)
  );

  assign run      = run_q;
  assign phase    = phase_q;
  assign dot_tick = dot_tick_q;
  assign clk_phi  = clk_phi_q;
  assign phi_rise = phi_rise_q;
  assign phi_fall = phi_fall_q;

endmodule

// File: tb/tb_phi_phase_gen.sv
// Self-checking bench for phi_phase_gen with a short settle time.
module tb_phi_phase_gen;

  localparam int SETTLE = 16;

  logic       clk_dot4x = 1'b0;
  logic       rst_n;
  logic [1:0] chip;
  logic       run;
  logic [4:0] phase;
  logic       dot_tick;
  logic       clk_phi;
  logic       phi_rise;
  logic       phi_fall;
  logic       ras_n;
  logic       cas_n;

  int tests = 0;
  int fails = 0;

  // Reference model: time-based description of the phi generator.
  bit         m_active;     // phi generation running
  bit         m_draining;   // chip change seen, finishing current cycle
  bit         m_have_chip;  // a baseline chip value has been captured
  int         m_done;       // consecutive quiet settle ticks completed
  int         m_t;          // ticks since phi generation started
  logic [1:0] m_last_chip;
  int         hi_len;       // consecutive ticks clk_phi has been observed high

  phi_phase_gen #(
    .SETTLE_TICKS (SETTLE),
    .RAS_FALL     (5),
    .CAS_FALL     (9),
    .STROBE_END   (14)
  ) dut (
    .clk_dot4x (clk_dot4x),
    .rst_n     (rst_n),
    .chip      (chip),
    .run       (run),
    .phase     (phase),
    .dot_tick  (dot_tick),
    .clk_phi   (clk_phi),
    .phi_rise  (phi_rise),
    .phi_fall  (phi_fall),
    .ras_n     (ras_n),
    .cas_n     (cas_n)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_active    = 1'b0;
    m_draining  = 1'b0;
    m_have_chip = 1'b0;
    m_done      = 0;
    m_t         = 0;
  endfunction

  function automatic void model_edge(input logic [1:0] c);
    bit change;
    change = m_have_chip && (c != m_last_chip);
    if (!m_active) begin
      m_done = change ? 0 : m_done + 1;
      if (m_done == SETTLE) begin
        m_active = 1'b1;
        m_t      = 0;
      end
    end else if (m_draining && (m_t % 32) == 31) begin
      m_active   = 1'b0;
      m_draining = 1'b0;
      m_done     = 0;
    end else begin
      m_t++;
      if (change) m_draining = 1'b1;
    end
    m_last_chip = c;
    m_have_chip = 1'b1;
  endfunction

  task automatic check_outputs();
    int ph;
    int hp;
    bit a;
    a  = m_active;
    ph = a ? (m_t % 32) : 0;
    hp = ph % 16;
    check("run",      run,      a);
    check("phase",    phase,    ph);
    check("dot_tick", dot_tick, a && (ph % 4 == 3));
    check("clk_phi",  clk_phi,  a && (ph >= 16));
    check("phi_rise", phi_rise, a && (ph == 15));
    check("phi_fall", phi_fall, a && (ph == 31));
    check("ras_n",    ras_n,    !(a && hp >= 5 && hp < 14));
    check("cas_n",    cas_n,    !(a && hp >= 9 && hp < 14));
    check("inv_cas_without_ras",  (!cas_n) && ras_n, 1'b0);
    check("inv_rise_fall_same",   phi_rise && phi_fall, 1'b0);
  endtask

  // One dot4x tick: model follows the edge, outputs are checked on the falling edge.
  task automatic tick();
    @(posedge clk_dot4x);
    model_edge(chip);
    @(negedge clk_dot4x);
    check_outputs();
    if (clk_phi) begin
      hi_len++;
    end else begin
      if (hi_len != 0) check("phi_high_len", hi_len, 16);
      hi_len = 0;
    end
  endtask

  task automatic wait_phase(input int target, input string tag);
    int n;
    n = 0;
    while (!(run && phase == 5'(target)) && n < 80) begin
      tick();
      n++;
    end
    check(tag, run && (phase == 5'(target)), 1'b1);
  endtask

  task automatic count_settle(input string tag);
    int n;
    n = 0;
    while (!run && n < 60) begin
      tick();
      n++;
    end
    check(tag, n, SETTLE);
  endtask

  initial begin
    int         n;
    int         n_dot;
    int         rise_at;
    int         last_ph;
    logic       prev_phi;
    logic [31:0] ras_mask;
    logic [31:0] cas_mask;

    rst_n = 1'b0;
    chip  = 2'b01;
    hi_len = 0;
    model_reset();
    repeat (3) @(negedge clk_dot4x);
    check_outputs();
    rst_n = 1'b1;

    // Settle wait: quiet for SETTLE ticks, then run with phase 0.
    for (int i = 0; i < SETTLE - 1; i++) begin
      tick();
      check("t1_run_low", run, 1'b0);
      check("t1_ras_high", ras_n, 1'b1);
    end
    tick();
    check("t1_run_high", run, 1'b1);
    check("t1_phase0", phase, 5'd0);

    // Two phi cycles: period, dot_tick count, edge strobe phases.
    n_dot    = 0;
    rise_at  = -1;
    prev_phi = clk_phi;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (dot_tick) n_dot++;
      if (phi_rise) check("t2_rise_phase", phase, 5'd15);
      if (phi_fall) check("t2_fall_phase", phase, 5'd31);
      if (clk_phi && !prev_phi) begin
        if (rise_at >= 0) check("t2_phi_period", i - rise_at, 32);
        rise_at = i;
      end
      prev_phi = clk_phi;
    end
    check("t2_dot_ticks", n_dot, 16);

    // Strobe windows over one full cycle.
    ras_mask = '0;
    cas_mask = '0;
    for (int i = 0; i < 32; i++) begin
      tick();
      ras_mask[phase] = !ras_n;
      cas_mask[phase] = !cas_n;
    end
    check("t3_ras_mask", ras_mask, 32'h3FE0_3FE0);
    check("t3_cas_mask", cas_mask, 32'h3E00_3E00);

    // Chip change at phase 7: finish the cycle, then a full settle.
    wait_phase(7, "t4_reach_phase7");
    chip    = 2'b00;
    n       = 0;
    last_ph = 0;
    while (run && n < 60) begin
      last_ph = phase;
      tick();
      n++;
    end
    check("t4_drain_ticks", n, 25);
    check("t4_last_phase", last_ph, 31);
    count_settle("t4_resettle_ticks");

    // Asynchronous reset in the middle of a cycle.
    wait_phase(20, "t5_reach_phase20");
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_run",      run,      1'b0);
    check("t5_phase",    phase,    5'd0);
    check("t5_dot_tick", dot_tick, 1'b0);
    check("t5_clk_phi",  clk_phi,  1'b0);
    check("t5_phi_rise", phi_rise, 1'b0);
    check("t5_phi_fall", phi_fall, 1'b0);
    check("t5_ras_n",    ras_n,    1'b1);
    check("t5_cas_n",    cas_n,    1'b1);
    model_reset();
    hi_len = 0;
    @(negedge clk_dot4x);
    check_outputs();
    rst_n = 1'b1;
    count_settle("t5_settle_after_reset");

    // Change at phase 3, then two more changes while draining: one drain only.
    wait_phase(3, "t6_reach_phase3");
    chip    = 2'b11;
    n       = 0;
    last_ph = 0;
    while (run && n < 60) begin
      if (n == 6)  chip = 2'b10;
      if (n == 15) chip = 2'b11;
      last_ph = phase;
      tick();
      n++;
    end
    check("t6_drain_ticks", n, 29);
    check("t6_last_phase", last_ph, 31);
    count_settle("t6_single_settle");

    // Random chip changes against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 47) == 0) chip = 2'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
